secuenciador_registro: RTL and testbench
========================================

// Module: secuenciador_registro
// PURPOSE
//  Test sequencer for the W-bit shift-register pair (structural vs behavioural).
//  - Drives the shared controls (MODO, D, S_IN, ENB) of both registers.
//  - Waits SETTLE cycles after every operation, so the slow structural output
//    (48 ns after the clock edge) has settled before Qe/Qc are compared.
//  - Counts mismatches and flags them on ALERTA.
//  - Sits between the bench clock/reset and the two registers, replacing free-running stimulus.
// PARAMETERS
//  W        32  register width
//  N_SHIFT  32  shift-left steps, then shift-right steps, per run (1..255)
//  SETTLE   2   idle cycles between an operation and its compare (>=1)
// PORTS
//  CLK      in   1   clock; all logic on posedge
//  RESET    in   1   synchronous, active-high reset
//  START    in   1   run request; sampled only in IDLE or DONE
//  SEED     in   W   parallel-load value for the run
//  Qe       in   W   structural register output
//  Qc       in   W   behavioural register output
//  MODO     out  2   00 hold, 01 shift left, 10 shift right, 11 parallel load
//  ENB      out  1   register enable; high only in an operation cycle
//  D        out  W   parallel data to both registers
//  S_IN     out  1   serial input bit to both registers
//  BUSY     out  1   high from LOAD through the last CHECK
//  DONE     out  1   high in DONE state until the next START or RESET
//  ERR_CNT  out  8   mismatch count, saturating at 255
//  ALERTA   out  1   one-cycle pulse in the cycle after a mismatching CHECK
// BEHAVIOUR
//  - Reset (CLK edge with RESET=1): state IDLE.
//    - All outputs 0: MODO=00, ENB=0, D=0, S_IN=0, BUSY=0, DONE=0, ERR_CNT=0, ALERTA=0.
//    - Step counter and settle counter = 0.
//    - RESET wins over all other inputs; mid-run it aborts to IDLE on that edge.
//  - States: IDLE, LOAD, WAIT, CHECK, SHL, SHR, DONE. All outputs are registered.
//  - START=1 in IDLE or DONE:
//    - Go to LOAD; capture SEED into D.
//    - Clear ERR_CNT and DONE; reload the S_IN generator.
//  - START while BUSY: ignored.
//  - LOAD (1 cycle): MODO=11, ENB=1 -> WAIT.
//  - SHL / SHR (1 cycle): MODO=01 / 10, ENB=1; S_IN holds the current pattern bit -> WAIT.
//    - The pattern generator advances at the end of each SHL/SHR cycle.
//  - WAIT (exactly SETTLE cycles): MODO=00, ENB=0 -> CHECK.
//  - CHECK (1 cycle): compare Qe vs Qc.
//    - On mismatch: ERR_CNT += 1 (held at 255 once reached); ALERTA=1 on the next cycle only.
//    - Next state:
//      - SHL while the number of left steps done < N_SHIFT;
//      - else SHR while the number of right steps done < N_SHIFT;
//      - else DONE.
//  - One step = SETTLE+2 cycles; a run has 1+2*N_SHIFT steps.
//  - DONE rises (1+2*N_SHIFT)*(SETTLE+2) cycles after the LOAD cycle begins.
//  - DONE: BUSY=0, DONE=1, ERR_CNT held, outputs as in WAIT.
//  - D is held at SEED for the whole run; it returns to 0 only on reset.
// CONFIGURATION
//  PATRON_LFSR_EN undefined (default):
//    - S_IN toggles per shift step, starting at 1: 1,0,1,0,...
//  PATRON_LFSR_EN defined:
//    - 16-bit Fibonacci LFSR, loaded with 16'hACE1 on START.
//    - S_IN = lfsr[0]; feedback = lfsr[0]^lfsr[2]^lfsr[3]^lfsr[5].
//    - Each advance: lfsr = {fb, lfsr[15:1]}.
//    - First S_IN bits of a run: 1,0,0,0.
// TESTING
//  1 RESET=1 for 2 edges -> every output 0, BUSY=0, DONE=0.
//  2 N_SHIFT=4, SETTLE=2, SEED=32'hA5A50F0F, Qe=Qc tied, START pulse:
//    -> LOAD cycle has MODO=11, D=A5A50F0F; DONE rises 36 cycles after LOAD begins;
//       ERR_CNT=0; ALERTA never high.
//  3 As 2, but Qe=Qc^1 during the 2nd CHECK only -> ERR_CNT=1; a single ALERTA pulse
//    one cycle after that CHECK.
//  4 N_SHIFT=200, Qe=~Qc always -> 401 mismatches; ERR_CNT stops at 255; DONE=1.
//  5 START re-pulsed in SHL -> ignored, run completes normally.
//    RESET in SHR -> IDLE with all outputs 0 on that edge.
//    START afterwards -> clean full run.
//  6 Log S_IN at each SHL/SHR cycle:
//    - macro off -> 1,0,1,0,...
//    - PATRON_LFSR_EN -> 1,0,0,0 first, then matches the bench LFSR model.

Source files
------------

// File: rtl/secuenciador_registro.sv
// -----------------------------------------------------------------------------
// secuenciador_registro
//
// Test sequencer for a W-bit shift-register pair: a structural register (Qe)
// and a behavioural register (Qc). It drives the shared controls of both
// registers, waits SETTLE idle cycles after every operation so the slow
// structural output has settled, then compares Qe against Qc.
//
// Run sequence:
//   LOAD, then N_SHIFT shift-left steps, then N_SHIFT shift-right steps.
//   Each operation is followed by SETTLE WAIT cycles and one CHECK cycle.
//
// Optional feature (macro PATRON_LFSR_EN):
//   undefined : S_IN toggles on every shift step, starting at 1.
//   defined   : S_IN comes from a 16-bit Fibonacci LFSR seeded with 16'hACE1.
//
// Ports:
//   CLK       in   1  clock, all logic on posedge
//   RESET     in   1  synchronous, active-high reset
//   START     in   1  run request, sampled only in IDLE or DONE
//   SEED      in   W  parallel-load value for the run
//   Qe        in   W  structural register output
//   Qc        in   W  behavioural register output
//   MODO      out  2  00 hold, 01 shift left, 10 shift right, 11 parallel load
//   ENB       out  1  register enable, high only in an operation cycle
//   D         out  W  parallel data, holds SEED for the whole run
//   S_IN      out  1  serial input bit
//   BUSY      out  1  high from LOAD through the last CHECK
//   DONE      out  1  high in DONE until the next START or RESET
//   ERR_CNT   out  8  mismatch count, saturating at 255
//   ALERTA    out  1  one-cycle pulse after a mismatching CHECK
//   state_dbg out  3  current FSM state (debug)
// -----------------------------------------------------------------------------
module secuenciador_registro #(
   parameter int W       = 32,
   parameter int N_SHIFT = 32,
   parameter int SETTLE  = 2
) (
   input  logic         CLK,
   input  logic         RESET,
   input  logic         START,
   input  logic [W-1:0] SEED,
   input  logic [W-1:0] Qe,
   input  logic [W-1:0] Qc,
   output logic [1:0]   MODO,
   output logic         ENB,
   output logic [W-1:0] D,
   output logic         S_IN,
   output logic         BUSY,
   output logic         DONE,
   output logic [7:0]   ERR_CNT,
   output logic         ALERTA,
   output logic [2:0]   state_dbg
);

   localparam int         SW      = (SETTLE < 2) ? 1 : $clog2(SETTLE);
   localparam logic [8:0] N_LEFT  = 9'(N_SHIFT);
   localparam logic [8:0] N_TOTAL = 9'(2 * N_SHIFT);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LOAD  = 3'd1,
      ST_WAIT  = 3'd2,
      ST_CHECK = 3'd3,
      ST_SHL   = 3'd4,
      ST_SHR   = 3'd5,
      ST_DONE  = 3'd6
   } state_t;

   state_t        state, state_next;
   logic [8:0]    step_cnt, step_next;     // shift steps done in this run
   logic [SW-1:0] settle_cnt, settle_next;
   logic [1:0]    modo_next;
   logic          enb_next, sin_next, busy_next, done_next, alerta_next;
   logic [W-1:0]  d_next;
   logic [7:0]    err_next;
   logic          gen_load, gen_adv, pat_bit;

   assign state_dbg = state;

   // Serial pattern generator: reloaded on START, advanced at the end of
   // every SHL/SHR cycle. pat_bit is the bit presented in the next shift.
`ifdef PATRON_LFSR_EN
   logic [15:0] lfsr;
   logic        lfsr_fb;

   assign lfsr_fb = lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5];
   assign pat_bit = lfsr[0];

   always_ff @(posedge CLK) begin
      if (RESET)         lfsr <= 16'h0000;
      else if (gen_load) lfsr <= 16'hACE1;
      else if (gen_adv)  lfsr <= {lfsr_fb, lfsr[15:1]};
   end
`else
   logic toggle;

   assign pat_bit = toggle;

   always_ff @(posedge CLK) begin
      if (RESET)         toggle <= 1'b0;
      else if (gen_load) toggle <= 1'b1;
      else if (gen_adv)  toggle <= ~toggle;
   end
`endif

   always_comb begin
      state_next  = state;
      step_next   = step_cnt;
      settle_next = settle_cnt;
      d_next      = D;
      err_next    = ERR_CNT;
      alerta_next = 1'b0;
      gen_load    = 1'b0;
      gen_adv     = 1'b0;
      modo_next   = 2'b00;
      enb_next    = 1'b0;
      sin_next    = 1'b0;
      busy_next   = 1'b0;
      done_next   = 1'b0;

      case (state)
         ST_IDLE, ST_DONE: begin
            if (START) begin
               state_next  = ST_LOAD;
               d_next      = SEED;
               err_next    = 8'd0;
               step_next   = 9'd0;
               settle_next = '0;
               gen_load    = 1'b1;
            end
         end
         ST_LOAD: state_next = ST_WAIT;
         ST_WAIT: begin
            if (settle_cnt == SW'(SETTLE - 1)) begin
               state_next  = ST_CHECK;
               settle_next = '0;
            end else begin
               settle_next = settle_cnt + SW'(1);
            end
         end
         ST_CHECK: begin
            if (Qe != Qc) begin
               alerta_next = 1'b1;
               if (ERR_CNT != 8'hFF) err_next = ERR_CNT + 8'd1;
            end
            if (step_cnt < N_LEFT)       state_next = ST_SHL;
            else if (step_cnt < N_TOTAL) state_next = ST_SHR;
            else                         state_next = ST_DONE;
         end
         ST_SHL, ST_SHR: begin
            state_next = ST_WAIT;
            step_next  = step_cnt + 9'd1;
            gen_adv    = 1'b1;
         end
         default: state_next = ST_IDLE;
      endcase

      // Outputs are decoded from the next state and registered, so they are
      // aligned with the state they describe.
      case (state_next)
         ST_LOAD: begin
            modo_next = 2'b11;
            enb_next  = 1'b1;
            busy_next = 1'b1;
         end
         ST_SHL: begin
            modo_next = 2'b01;
            enb_next  = 1'b1;
            sin_next  = pat_bit;
            busy_next = 1'b1;
         end
         ST_SHR: begin
            modo_next = 2'b10;
            enb_next  = 1'b1;
            sin_next  = pat_bit;
            busy_next = 1'b1;
         end
         ST_WAIT, ST_CHECK: busy_next = 1'b1;
         ST_DONE:           done_next = 1'b1;
         default:           ;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state      <= ST_IDLE;
         step_cnt   <= 9'd0;
         settle_cnt <= '0;
         MODO       <= 2'b00;
         ENB        <= 1'b0;
         D          <= '0;
         S_IN       <= 1'b0;
         BUSY       <= 1'b0;
         DONE       <= 1'b0;
         ERR_CNT    <= 8'd0;
         ALERTA     <= 1'b0;
      end else begin
         state      <= state_next;
         step_cnt   <= step_next;
         settle_cnt <= settle_next;
         MODO       <= modo_next;
         ENB        <= enb_next;
         D          <= d_next;
         S_IN       <= sin_next;
         BUSY       <= busy_next;
         DONE       <= done_next;
         ERR_CNT    <= err_next;
         ALERTA     <= alerta_next;
      end
   end

endmodule

// File: tb/tb_secuenciador_registro.sv
// -----------------------------------------------------------------------------
// tb_secuenciador_registro
//
// Directed bench for secuenciador_registro. Instance dut_a uses N_SHIFT=4,
// SETTLE=2 (36-cycle run); instance dut_b uses N_SHIFT=200 to reach the
// ERR_CNT saturation. Expected per-cycle values come from the run timeline:
// LOAD at cycle 0, shift k at cycle 4k, CHECK k at cycle 4k-1, DONE at 36.
// -----------------------------------------------------------------------------
module tb_secuenciador_registro;

   logic        clk = 1'b0;
   logic        reset;

   logic        start_a, start_b;
   logic [31:0] seed_a, qe_a, qc_a, seed_b, qe_b, qc_b;
   logic [1:0]  modo_a, modo_b;
   logic        enb_a, sin_a, busy_a, done_a, alerta_a;
   logic        enb_b, sin_b, busy_b, done_b, alerta_b;
   logic [31:0] d_a, d_b;
   logic [7:0]  err_a, err_b;
   logic [2:0]  st_a, st_b;

   int n_checks = 0;
   int n_errors = 0;

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   secuenciador_registro #(.W(32), .N_SHIFT(4), .SETTLE(2)) dut_a (
      .CLK(clk), .RESET(reset), .START(start_a), .SEED(seed_a),
      .Qe(qe_a), .Qc(qc_a), .MODO(modo_a), .ENB(enb_a), .D(d_a),
      .S_IN(sin_a), .BUSY(busy_a), .DONE(done_a), .ERR_CNT(err_a),
      .ALERTA(alerta_a), .state_dbg(st_a)
   );

   secuenciador_registro #(.W(32), .N_SHIFT(200), .SETTLE(2)) dut_b (
      .CLK(clk), .RESET(reset), .START(start_b), .SEED(seed_b),
      .Qe(qe_b), .Qc(qc_b), .MODO(modo_b), .ENB(enb_b), .D(d_b),
      .S_IN(sin_b), .BUSY(busy_b), .DONE(done_b), .ERR_CNT(err_b),
      .ALERTA(alerta_b), .state_dbg(st_b)
   );

   // ---------------- checking ----------------
   task automatic check_val(input string tag, input logic [63:0] got,
                            input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // ---------------- driver tasks ----------------
   // Advance one clock; sample 1 time unit after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_idle_a(input string tag);
      check_val({tag, " modo"},   64'(modo_a),   64'd0);
      check_val({tag, " enb"},    64'(enb_a),    64'd0);
      check_val({tag, " d"},      64'(d_a),      64'd0);
      check_val({tag, " s_in"},   64'(sin_a),    64'd0);
      check_val({tag, " busy"},   64'(busy_a),   64'd0);
      check_val({tag, " done"},   64'(done_a),   64'd0);
      check_val({tag, " err"},    64'(err_a),    64'd0);
      check_val({tag, " alerta"}, 64'(alerta_a), 64'd0);
      check_val({tag, " state"},  64'(st_a),     64'd0);
   endtask

   // One run on dut_a. bad_check: CHECK index (1-based) at which Qe differs
   // from Qc (0 = none). restart_at: cycle at which START is re-pulsed.
   // abort_at: cycle during which RESET is raised (-1 = never).
   task automatic run_a(input logic [31:0] seed, input int bad_check,
                        input int restart_at, input int abort_at,
                        input string name);
      int          err_exp;
      int          s;
      logic [1:0]  e_modo;
      logic        e_enb, e_busy, e_done, e_alerta, e_sin;
      logic        tog_m;
      logic [15:0] lfsr_m;
      logic        fb;
      err_exp = 0;
      tog_m   = 1'b1;
      lfsr_m  = 16'hACE1;
      seed_a  = seed;
      qe_a    = qc_a;
      start_a = 1'b1;
      tick();
      start_a = 1'b0;
      for (int i = 0; i <= 36; i++) begin
         s      = i / 4;
         e_modo = 2'b00;
         e_enb  = 1'b0;
         e_busy = 1'b1;
         e_done = 1'b0;
         if (i == 36) begin
            e_busy = 1'b0;
            e_done = 1'b1;
         end else if (i == 0) begin
            e_modo = 2'b11;
            e_enb  = 1'b1;
         end else if (i % 4 == 0) begin
            e_modo = (s <= 4) ? 2'b01 : 2'b10;
            e_enb  = 1'b1;
         end
         e_alerta = (bad_check > 0) && (i == 4 * bad_check);
         if (e_alerta) err_exp++;
         check_val($sformatf("%s modo c%0d", name, i),   64'(modo_a),   64'(e_modo));
         check_val($sformatf("%s enb c%0d", name, i),    64'(enb_a),    64'(e_enb));
         check_val($sformatf("%s busy c%0d", name, i),   64'(busy_a),   64'(e_busy));
         check_val($sformatf("%s done c%0d", name, i),   64'(done_a),   64'(e_done));
         check_val($sformatf("%s alerta c%0d", name, i), 64'(alerta_a), 64'(e_alerta));
         check_val($sformatf("%s err c%0d", name, i),    64'(err_a),    64'(err_exp));
         check_val($sformatf("%s d c%0d", name, i),      64'(d_a),      64'(seed));
         if (e_enb && i > 0) begin
`ifdef PATRON_LFSR_EN
            e_sin  = lfsr_m[0];
            fb     = lfsr_m[0] ^ lfsr_m[2] ^ lfsr_m[3] ^ lfsr_m[5];
            lfsr_m = {fb, lfsr_m[15:1]};
`else
            e_sin  = tog_m;
            tog_m  = ~tog_m;
`endif
            check_val($sformatf("%s s_in step%0d", name, s), 64'(sin_a), 64'(e_sin));
         end
         start_a = (i == restart_at);
         qe_a    = (bad_check > 0 && i == 4 * bad_check - 1) ? (qc_a ^ 32'h1) : qc_a;
         if (i == abort_at) begin
            reset = 1'b1;
            tick();
            reset   = 1'b0;
            start_a = 1'b0;
            qe_a    = qc_a;
            check_idle_a({name, " after_reset"});
            return;
         end
         tick();
      end
      start_a = 1'b0;
      qe_a    = qc_a;
      repeat (3) tick();
      check_val({name, " done_hold"}, 64'(done_a), 64'd1);
      check_val({name, " busy_hold"}, 64'(busy_a), 64'd0);
      check_val({name, " err_hold"},  64'(err_a),  64'(err_exp));
      check_val({name, " modo_hold"}, 64'(modo_a), 64'd0);
      check_val({name, " enb_hold"},  64'(enb_a),  64'd0);
   endtask

   // Long run on dut_b with Qe = ~Qc at every CHECK (401 mismatches).
   task automatic run_b();
      int done_at;
      done_at = -1;
      seed_b  = 32'hCAFE_F00D;
      start_b = 1'b1;
      tick();
      start_b = 1'b0;
      check_val("b load modo", 64'(modo_b), 64'd3);
      check_val("b load d",    64'(d_b),    64'hCAFE_F00D);
      for (int i = 0; i < 2000; i++) begin
         if (i == 4 * 254) check_val("b err 254", 64'(err_b), 64'd254);
         if (i == 4 * 255) check_val("b err 255", 64'(err_b), 64'd255);
         if (i == 1200) begin
            check_val("b alerta saturated", 64'(alerta_b), 64'd1);
            check_val("b err held",         64'(err_b),    64'd255);
         end
         if (i == 1201) check_val("b alerta single", 64'(alerta_b), 64'd0);
         if (done_b) begin
            done_at = i;
            break;
         end
         tick();
      end
      check_val("b done cycle", 64'(done_at), 64'd1604);
      check_val("b err final",  64'(err_b),   64'd255);
      check_val("b busy final", 64'(busy_b),  64'd0);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      reset   = 1'b1;
      start_a = 1'b0;
      start_b = 1'b0;
      seed_a  = 32'h0;
      seed_b  = 32'h0;
      qc_a    = 32'h1234_5678;
      qe_a    = qc_a;
      qc_b    = 32'h0F0F_3C3C;
      qe_b    = ~qc_b;
      tick();
      tick();
      check_idle_a("reset a");
      check_val("reset b modo", 64'(modo_b), 64'd0);
      check_val("reset b busy", 64'(busy_b), 64'd0);
      check_val("reset b done", 64'(done_b), 64'd0);
      check_val("reset b err",  64'(err_b),  64'd0);
      reset = 1'b0;
      tick();

      run_a(32'hA5A5_0F0F, 0, -1, -1, "clean");
      run_a(32'hA5A5_0F0F, 2, -1, -1, "one_err");
      run_a(32'h0000_FFFF, 0,  4, -1, "restart_shl");
      run_a(32'hDEAD_BEEF, 1, -1, 20, "abort_shr");
      tick();
      run_a(32'h1357_9BDF, 0, -1, -1, "after_abort");
      run_b();

      // ---------------- report ----------------
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
